// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message padder:
//   state_t    - padder FSM state encoding
//   PAD_WORD   - word carrying the single '1' bit that follows the message
//   LEN_POS    - word slot (mod 16) where the 64-bit length field begins
//   IDX_W      - width of the word index / padded word count
//   bit_len()  - message length in bits from a clamped word count
// -----------------------------------------------------------------------------
package sha256_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ACCEPT    = 4'd1,
      ST_PAD       = 4'd2,
      ST_ZERO      = 4'd3,
      ST_LEN_HI    = 4'd4,
      ST_LEN_LO    = 4'd5,
      ST_KICK      = 4'd6,
      ST_WAIT_BUSY = 4'd7,
      ST_WAIT_DONE = 4'd8
   } state_t;

   localparam logic [31:0] PAD_WORD = 32'h8000_0000;
   localparam logic [3:0]  LEN_POS  = 4'd14;

   // 1000 words pad out to at most 1024, which needs 11 bits.
   localparam int IDX_W = 11;

   // Bit length of an n-word message (n * 32), zero-extended to one word.
   function automatic logic [31:0] bit_len(input logic [IDX_W-1:0] n);
      return {16'h0000, n, 5'b00000};
   endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
// Accepts a message as a stream of big-endian 32-bit words, writes it to a
// word-addressed memory starting at msg_base, appends SHA-256 padding
// (0x80000000, zero words, 64-bit big-endian bit length) up to a multiple of
// 16 words, then pulses hash_start and waits for the core to finish.
//
// Ports
//   clk            in   clock, all state on rising edge
//   reset          in   asynchronous active-high reset
//   msg_base[15:0] in   word address of first padded word (sampled on 1st beat)
//   in_valid       in   upstream word valid
//   in_data[31:0]  in   message word
//   in_last        in   final message word
//   in_ready       out  a word is accepted this cycle when in_valid is high
//   mem_we         out  memory write strobe (registered)
//   mem_addr[15:0] out  memory word address (registered)
//   mem_write_data out  memory write data (registered)
//   hash_start     out  one-cycle start pulse to the SHA-256 core
//   hash_done      in   core done level, high while the core is idle
//   padded_words   out  words written for the last message (multiple of 16)
//   busy           out  high in every state except IDLE
//   overflow       out  sticky: a beat beyond MAX_WORDS was offered
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state, never on in_valid. While in_ready
// is low, in_valid is ignored and upstream is expected to hold its word.
// -----------------------------------------------------------------------------
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int MAX_WORDS = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      msg_base,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             mem_we,
   output logic [15:0]      mem_addr,
   output logic [31:0]      mem_write_data,
   output logic             hash_start,
   input  logic             hash_done,
   output logic [IDX_W-1:0] padded_words,
   output logic             busy,
   output logic             overflow
);

   localparam logic [IDX_W-1:0] MAX_W = IDX_W'(MAX_WORDS);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;       // index of the next word to write
   logic [IDX_W-1:0] r_nwords;    // clamped message length in words
   logic [15:0]      r_base;
   logic             r_mem_we;
   logic [15:0]      r_mem_addr;
   logic [31:0]      r_mem_data;
   logic             r_hash_start;
   logic [IDX_W-1:0] r_padded;
   logic             r_overflow;

   logic [IDX_W-1:0] w_idx_inc;
   logic [15:0]      w_addr;
   logic             w_room;
   logic             w_next_is_len;

   assign w_idx_inc     = r_idx + IDX_W'(1);
   // 16-bit add wraps naturally at the top of the address space.
   assign w_addr        = r_base + 16'(r_idx);
   assign w_room        = (r_idx < MAX_W);
   // The length field occupies slots 14 and 15 of the final 16-word block.
   assign w_next_is_len = (w_idx_inc[3:0] == LEN_POS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_nwords     <= '0;
         r_base       <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_hash_start <= 1'b0;
         r_padded     <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_mem_we     <= 1'b0;
         r_hash_start <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_base     <= msg_base;
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= msg_base;
                  r_mem_data <= in_data;
                  r_idx      <= IDX_W'(1);
                  r_overflow <= 1'b0;
                  if (in_last) begin
                     r_nwords <= IDX_W'(1);
                     r_state  <= ST_PAD;
                  end else begin
                     r_state  <= ST_ACCEPT;
                  end
               end
            end

            ST_ACCEPT: begin
               if (in_valid) begin
                  // Beats past MAX_WORDS are consumed but not stored.
                  if (w_room) begin
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= w_addr;
                     r_mem_data <= in_data;
                     r_idx      <= w_idx_inc;
                  end else begin
                     r_overflow <= 1'b1;
                  end
                  if (in_last) begin
                     r_nwords <= w_room ? w_idx_inc : r_idx;
                     r_state  <= ST_PAD;
                  end
               end
            end

            ST_PAD: begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= w_addr;
               r_mem_data <= PAD_WORD;
               r_idx      <= w_idx_inc;
               r_state    <= w_next_is_len ? ST_LEN_HI : ST_ZERO;
            end

            ST_ZERO: begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= w_addr;
               r_mem_data <= 32'h0;
               r_idx      <= w_idx_inc;
               if (w_next_is_len) begin
                  r_state <= ST_LEN_HI;
               end
            end

            ST_LEN_HI: begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= w_addr;
               r_mem_data <= 32'h0;
               r_idx      <= w_idx_inc;
               r_state    <= ST_LEN_LO;
            end

            ST_LEN_LO: begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= w_addr;
               r_mem_data <= bit_len(r_nwords);
               r_padded   <= w_idx_inc;
               r_state    <= ST_KICK;
            end

            // The LEN_LO write is on the bus during this state, so the start
            // pulse appears only after the whole block is in memory.
            ST_KICK: begin
               r_hash_start <= 1'b1;
               r_state      <= ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
               if (!hash_done) begin
                  r_state <= ST_WAIT_DONE;
               end
            end

            ST_WAIT_DONE: begin
               if (hash_done) begin
                  r_idx   <= '0;
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready       = (r_state == ST_IDLE) || (r_state == ST_ACCEPT);
   assign busy           = (r_state != ST_IDLE);
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_write_data = r_mem_data;
   assign hash_start     = r_hash_start;
   assign padded_words   = r_padded;
   assign overflow       = r_overflow;

endmodule
